// File: rtl/lampfpu_fractsqrt_sched_pkg.sv
// Shared types and constants for the fractional sqrt/inverse-sqrt scheduler.
package lampfpu_fractsqrt_sched_pkg;

   localparam int unsigned LAMP_FLOAT_F_DW         = 7;
   localparam int unsigned LAMP_SQRT_SCHED_TIMEOUT = 16;

   typedef enum logic {
      LAMP_SQRT_OP    = 1'b0,
      LAMP_INVSQRT_OP = 1'b1
   } lampFPU_sqrtOp_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } lampFPU_sqrtSchedState_t;

endpackage

// File: rtl/lampfpu_rr_pick.sv
// Combinational round-robin picker: first valid requester searching upward from ptr+1.
module lampfpu_rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IdxW-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IdxW-1:0]    idx
);

   logic            found;
   logic [IdxW-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IdxW'((32'(ptr) + i) % NUM_REQ);
         if (!found && valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      if (found) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/lampfpu_fractsqrt_sched.sv
// Round-robin scheduler sharing one fractional sqrt/invsqrt core among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining LAMP_FRACTSQRT_SCHED_TIMEOUT_EN.
module lampfpu_fractsqrt_sched
   import lampfpu_fractsqrt_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned F_DW        = LAMP_FLOAT_F_DW,
   parameter int unsigned TIMEOUT_CYC = LAMP_SQRT_SCHED_TIMEOUT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   input  logic [NUM_REQ-1:0]          req_op_i,
   input  logic [NUM_REQ*(F_DW+2)-1:0] req_f_i,
   output logic [NUM_REQ-1:0]          rsp_valid_o,
   input  logic [NUM_REQ-1:0]          rsp_ready_i,
   output logic [2*(F_DW+1)-1:0]       rsp_result_o,
   output logic                        core_doSqrt_o,
   output logic                        core_doInvSqrt_o,
   output logic [F_DW+1:0]             core_f_o,
   input  logic [2*(F_DW+1)-1:0]       core_result_i,
   input  logic                        core_valid_i,
   output logic                        busy_o,
   output logic                        timeout_o
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("lampfpu_fractsqrt_sched: illegal NUM_REQ or TIMEOUT_CYC");
   end

   lampFPU_sqrtSchedState_t state, next_state;
   lampFPU_sqrtOp_t         op;
   logic [F_DW+1:0]         f;
   logic [IdxW-1:0]         idx;
   logic [IdxW-1:0]         ptr;
   logic [2*(F_DW+1)-1:0]   result;
   logic [NUM_REQ-1:0]      pick_grant;
   logic [IdxW-1:0]         pick_idx;
   logic                    tmo_hit;

   lampfpu_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .valid (req_valid_i),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

`ifdef LAMP_FRACTSQRT_SCHED_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

   logic [CntW-1:0] wait_cnt;
   logic            tmo_flag;

   // Fires on the TIMEOUT_CYC-th WAIT cycle unless the core answers in that same cycle.
   assign tmo_hit   = (state == WAIT) && !core_valid_i && (wait_cnt == CntW'(TIMEOUT_CYC - 1));
   assign timeout_o = tmo_flag;

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         tmo_flag <= 1'b0;
      end else begin
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (tmo_hit) tmo_flag <= 1'b1;
      end
   end
`else
   assign tmo_hit   = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (|req_valid_i) next_state = ISSUE;
         ISSUE:   next_state = WAIT;
         WAIT:    if (core_valid_i || tmo_hit) next_state = RESP;
         RESP:    if (rsp_ready_i[idx]) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o      = '0;
      rsp_valid_o      = '0;
      rsp_result_o     = '0;
      core_doSqrt_o    = 1'b0;
      core_doInvSqrt_o = 1'b0;
      core_f_o         = (state == IDLE) ? '0 : f;
      busy_o           = (state != IDLE);
      case (state)
         IDLE:  req_ready_o = pick_grant;
         ISSUE: begin
            core_doSqrt_o    = (op == LAMP_SQRT_OP);
            core_doInvSqrt_o = (op == LAMP_INVSQRT_OP);
         end
         RESP: begin
            rsp_valid_o[idx] = 1'b1;
            rsp_result_o     = result;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr    <= IdxW'(NUM_REQ - 1);
         op     <= LAMP_SQRT_OP;
         f      <= '0;
         idx    <= '0;
         result <= '0;
      end else begin
         if (state == IDLE && |req_valid_i) begin
            op  <= lampFPU_sqrtOp_t'(req_op_i[pick_idx]);
            f   <= req_f_i[32'(pick_idx) * (F_DW + 2) +: (F_DW + 2)];
            idx <= pick_idx;
         end
         if (state == WAIT && core_valid_i) result <= core_result_i;
         if (tmo_hit) result <= '0;
         if (state == RESP && rsp_ready_i[idx]) ptr <= idx;
      end
   end

endmodule

// File: tb/tb_lampfpu_fractsqrt_sched.sv
// Scoreboard bench for lampfpu_fractsqrt_sched with a fixed 5-cycle core model.
module tb_lampfpu_fractsqrt_sched;

   localparam int NR  = 2;
   localparam int FW  = 9;
   localparam int RW  = 16;
   localparam int LAT = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid_i, req_ready_o, req_op_i, rsp_valid_o, rsp_ready_i;
   logic [NR*FW-1:0] req_f_i;
   logic [RW-1:0]   rsp_result_o, core_result_i;
   logic            core_doSqrt_o, core_doInvSqrt_o, core_valid_i, busy_o, timeout_o;
   logic [FW-1:0]   core_f_o;

   lampfpu_fractsqrt_sched dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .req_op_i         (req_op_i),
      .req_f_i          (req_f_i),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_ready_i      (rsp_ready_i),
      .rsp_result_o     (rsp_result_o),
      .core_doSqrt_o    (core_doSqrt_o),
      .core_doInvSqrt_o (core_doInvSqrt_o),
      .core_f_o         (core_f_o),
      .core_result_i    (core_result_i),
      .core_valid_i     (core_valid_i),
      .busy_o           (busy_o),
      .timeout_o        (timeout_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_sqrt   = 0;
   int n_inv    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Core model: answers {7'b0, f} exactly LAT cycles after a start pulse, unless muted.
   logic           core_mute = 1'b0;
   logic [LAT-1:0] vpipe;
   logic [RW-1:0]  dpipe [LAT];

   always @(posedge clk) begin
      if (rst) begin
         vpipe <= '0;
      end else begin
         vpipe    <= {vpipe[LAT-2:0], (core_doSqrt_o | core_doInvSqrt_o) & !core_mute};
         dpipe[0] <= {7'b0, core_f_o};
         for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
      end
   end

   assign core_valid_i  = vpipe[LAT-1];
   assign core_result_i = dpipe[LAT-1];

   typedef struct {
      int            idx;
      logic [RW-1:0] res;
      int            cyc;
   } exp_t;

   exp_t          sb[$];
   int            exp_grant[$];
   logic [FW-1:0] acc_f;
   logic          acc_op;
   logic [NR-1:0] rsp_prev;

   // Monitor: pushes expectations on accept, pops and compares on response handshake.
   initial begin
      acc_f    = '0;
      acc_op   = 1'b0;
      rsp_prev = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            rsp_prev = '0;
         end else begin
            if (req_ready_o != 0) begin
               int k;
               k = 0;
               for (int i = NR - 1; i >= 0; i--) if (req_ready_o[i]) k = i;
               check("ready_onehot", $countones(req_ready_o), 1);
               check("ready_valid", req_valid_i & req_ready_o, req_ready_o);
               if (exp_grant.size() > 0) check("grant_order", k, exp_grant.pop_front());
               acc_f  = req_f_i[k*FW +: FW];
               acc_op = req_op_i[k];
               sb.push_back('{idx: k, res: (core_mute ? 16'h0 : {7'b0, acc_f}), cyc: cyc});
            end
            if (core_doSqrt_o || core_doInvSqrt_o) begin
               n_sqrt += int'(core_doSqrt_o);
               n_inv  += int'(core_doInvSqrt_o);
               check("pulse_f", core_f_o, acc_f);
               check("pulse_op", core_doInvSqrt_o, acc_op);
               check("pulse_excl", core_doSqrt_o & core_doInvSqrt_o, 0);
            end
            if (rsp_valid_o != 0 && rsp_prev == 0 && sb.size() > 0)
               check("rsp_latency", cyc - sb[0].cyc, core_mute ? 18 : LAT + 2);
            if ((rsp_valid_o & rsp_ready_i) != 0) begin
               check("rsp_no_regrant", req_ready_o, 0);
               if (sb.size() == 0) begin
                  check("rsp_unexpected", rsp_valid_o, 0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("rsp_idx", rsp_valid_o, 1 << e.idx);
                  check("rsp_result", rsp_result_o, e.res);
               end
            end
            rsp_prev = rsp_valid_o;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_f(input int k, input logic [FW-1:0] v);
      req_f_i[k*FW +: FW] = v;
   endtask

   // Returns one tick after requester k is accepted (core is in ISSUE).
   task automatic wait_accept(input int k);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready_o[k]) break;
      end
      check("accept_seen", req_ready_o[k], 1);
      step();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy_o) break;
      end
      check("idle_seen", busy_o, 0);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ready"}, req_ready_o, 0);
      check({tag, "_rsp_valid"}, rsp_valid_o, 0);
      check({tag, "_rsp_result"}, rsp_result_o, 0);
      check({tag, "_pulses"}, {core_doSqrt_o, core_doInvSqrt_o}, 0);
      check({tag, "_core_f"}, core_f_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_timeout"}, timeout_o, 0);
   endtask

   initial begin
      int s0, i0;
      req_valid_i = '0;
      req_op_i    = '0;
      req_f_i     = '0;
      rsp_ready_i = 2'b11;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_quiet("reset");

      // Contention: both valid, requester 1 is invsqrt.
      step();
      set_f(0, 9'h0A5);
      set_f(1, 9'h1FF);
      req_op_i = 2'b10;
      exp_grant.push_back(0);
      exp_grant.push_back(1);
      exp_grant.push_back(0);
      exp_grant.push_back(1);
      s0 = n_sqrt;
      i0 = n_inv;
      req_valid_i = 2'b11;
      for (int j = 0; j < 4; j++) wait_accept(j % 2);
      req_valid_i = '0;
      wait_idle();
      check("contend_sqrt_pulses", n_sqrt - s0, 2);
      check("contend_inv_pulses", n_inv - i0, 2);
      check("contend_grants_left", exp_grant.size(), 0);

      // Single request, same-cycle ready.
      step();
      set_f(0, 9'h080);
      req_op_i = 2'b00;
      s0 = n_sqrt;
      i0 = n_inv;
      req_valid_i = 2'b01;
      @(negedge clk);
      check("single_ready", req_ready_o, 2'b01);
      step();
      req_valid_i = '0;
      wait_idle();
      check("single_sqrt_pulses", n_sqrt - s0, 1);
      check("single_inv_pulses", n_inv - i0, 0);

      // Reset two cycles after ISSUE; pointer must return to favour requester 0.
      step();
      set_f(1, 9'h0F0);
      req_valid_i = 2'b10;
      wait_accept(1);
      req_valid_i = '0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check_quiet("rst_wait");
      step();
      set_f(0, 9'h011);
      set_f(1, 9'h022);
      req_op_i = 2'b00;
      exp_grant.push_back(0);
      req_valid_i = 2'b11;
      wait_accept(0);
      req_valid_i = '0;
      wait_idle();

      // Response backpressure; the non-owner's ready must be ignored.
      step();
      rsp_ready_i = 2'b10;
      set_f(0, 9'h123);
      req_op_i = 2'b00;
      req_valid_i = 2'b01;
      wait_accept(0);
      set_f(1, 9'h042);
      req_op_i = 2'b10;
      req_valid_i = 2'b10;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid_o != 0) break;
      end
      check("bp_rsp_seen", rsp_valid_o, 2'b01);
      s0 = n_sqrt + n_inv;
      for (int j = 0; j < 10; j++) begin
         check("bp_valid", rsp_valid_o, 2'b01);
         check("bp_result", rsp_result_o, 16'h0123);
         check("bp_ready", req_ready_o, 0);
         check("bp_busy", busy_o, 1);
         @(negedge clk);
      end
      check("bp_pulses", n_sqrt + n_inv - s0, 0);
      step();
      rsp_ready_i = 2'b11;
      wait_accept(1);
      req_valid_i = '0;
      wait_idle();

`ifdef LAMP_FRACTSQRT_SCHED_TIMEOUT_EN
      step();
      core_mute = 1'b1;
      set_f(0, 9'h055);
      req_op_i = 2'b00;
      req_valid_i = 2'b01;
      wait_accept(0);
      req_valid_i = '0;
      wait_idle();
      check("tmo_flag", timeout_o, 1);
      step();
      core_mute = 1'b0;
      set_f(1, 9'h1AA);
      req_op_i = 2'b10;
      req_valid_i = 2'b10;
      wait_accept(1);
      req_valid_i = '0;
      wait_idle();
      check("tmo_sticky", timeout_o, 1);
`else
      step();
      core_mute = 1'b1;
      set_f(0, 9'h055);
      req_op_i = 2'b00;
      req_valid_i = 2'b01;
      wait_accept(0);
      req_valid_i = '0;
      repeat (40) @(negedge clk);
      check("hang_busy", busy_o, 1);
      check("hang_rsp", rsp_valid_o, 0);
      check("hang_timeout", timeout_o, 0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      core_mute = 1'b0;
      @(negedge clk);
      check_quiet("hang_reset");
`endif

      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1);
   end

endmodule
